vga_display_sequencer: RTL

- Controller that sequences the VGA display datapath: generates CURRENT_X/CURRENT_Y from the RGB-enable stream and selects the active pattern generator (MODE_SEL).
- Mode changes, manual or automatic, take effect only at frame boundaries, so a frame never tears.
- Detects a lost pixel stream mid-frame and resynchronises.
- Sits between the VGA timing interface and the pattern generators / RGB output mux.

---
 rtl/vga_seq_pkg.sv | 24 ++
 rtl/vga_xy_counter.sv | 73 +++++++
 rtl/vga_display_sequencer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/vga_seq_pkg.sv
// Shared definitions for the VGA display sequencer and its X/Y counter:
// FSM state encoding, default resolution, mode width and the mode-advance
// helper.
package vga_seq_pkg;

    localparam int unsigned COORD_W = 11;
    localparam int unsigned MODE_W  = 2;

    localparam logic [COORD_W-1:0] DISPLAY_X_DEF = 11'd1024;
    localparam logic [COORD_W-1:0] DISPLAY_Y_DEF = 11'd768;

    // Sequencer FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_RESYNC = 2'd2;

    typedef logic [MODE_W-1:0] mode_t;

    // Next mode in round-robin order over num_modes modes
    function automatic mode_t next_mode(input mode_t m, input int unsigned num_modes);
        next_mode = ((32'(m) + 32'd1) >= num_modes) ? '0 : m + mode_t'(1);
    endfunction

endpackage

// File: rtl/vga_xy_counter.sv
// Pixel X/Y counter driven by the active-video enable.
// PIX_VALID is the enable delayed one cycle; x/y describe the pixel presented
// while pix_valid=1 and advance after it. frame_start is registered together
// with the pixel it marks; frame_end_c flags the last pixel of a frame.
//
// Ports:
//   VGA_CLK, RST_N  clock, synchronous active-low reset
//   en_in           raw active-video enable
//   hold            suppress advancing (pixel presented this cycle is dropped)
//   clear           force the position back to (0,0)
//   pix_valid       registered en_in
//   x, y            current pixel position
//   frame_start     pix_valid at (0,0)
//   frame_end_c     pix_valid at the last pixel of the frame (combinational)
module vga_xy_counter
    import vga_seq_pkg::*;
#(
    parameter logic [10:0] P_DISPLAY_X = DISPLAY_X_DEF,
    parameter logic [10:0] P_DISPLAY_Y = DISPLAY_Y_DEF
) (
    input  logic        VGA_CLK,
    input  logic        RST_N,
    input  logic        en_in,
    input  logic        hold,
    input  logic        clear,
    output logic        pix_valid,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        frame_start,
    output logic        frame_end_c
);

    localparam logic [10:0] X_MAX = P_DISPLAY_X - 11'd1;
    localparam logic [10:0] Y_MAX = P_DISPLAY_Y - 11'd1;

    logic [10:0] x_nxt_c;
    logic [10:0] y_nxt_c;

    // Position after the current cycle
    always_comb begin
        x_nxt_c = x;
        y_nxt_c = y;
        if (clear) begin
            x_nxt_c = '0;
            y_nxt_c = '0;
        end else if (pix_valid && !hold) begin
            if (x == X_MAX) begin
                x_nxt_c = '0;
                y_nxt_c = (y == Y_MAX) ? 11'd0 : y + 11'd1;
            end else begin
                x_nxt_c = x + 11'd1;
            end
        end
    end

    assign frame_end_c = pix_valid && !hold && (x == X_MAX) && (y == Y_MAX);

    // frame_start is precomputed from the incoming enable so it lines up with the pixel
    always_ff @(posedge VGA_CLK) begin
        if (!RST_N) begin
            pix_valid   <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
        end else begin
            pix_valid   <= en_in;
            x           <= x_nxt_c;
            y           <= y_nxt_c;
            frame_start <= en_in && !clear && (x_nxt_c == 11'd0) && (y_nxt_c == 11'd0);
        end
    end

endmodule

// File: rtl/vga_display_sequencer.sv
// VGA display sequencer: tracks the pixel position from the RGB-enable stream,
// selects the active pattern mode (switching only at frame boundaries) and
// resynchronises after an over-long enable gap inside a frame.
//
// Build option: define VGA_SEQ_AUTO_CYCLE_EN to include the frame counter and
// automatic mode cycling controlled by AUTO_EN; otherwise AUTO_EN is ignored.
//
// Ports:
//   VGA_CLK, RST_N   pixel clock, synchronous active-low reset
//   VGA_IF_RGBEN     active-video enable from the timing generator
//   MODE_REQ         one-cycle request to switch to MODE_REQ_SEL
//   MODE_REQ_SEL     requested mode
//   AUTO_EN          level enable for automatic mode cycling
//   CURRENT_X/Y      position of the pixel qualified by PIX_VALID
//   PIX_VALID        VGA_IF_RGBEN delayed by one cycle
//   FRAME_START      pulse with pixel (0,0)
//   MODE_SEL         active mode, constant within a frame
//   MODE_CHANGED     pulse on the cycle MODE_SEL takes a new value
//   SYNC_ERR         sticky gap-timeout flag, cleared by reset
module vga_display_sequencer
    import vga_seq_pkg::*;
#(
    parameter logic [10:0] P_DISPLAY_X   = DISPLAY_X_DEF,
    parameter logic [10:0] P_DISPLAY_Y   = DISPLAY_Y_DEF,
    parameter int unsigned P_NUM_MODES   = 4,
    parameter logic [7:0]  P_AUTO_FRAMES = 8'd60,
    parameter logic [15:0] P_GAP_TIMEOUT = 16'd2048
) (
    input  logic        VGA_CLK,
    input  logic        RST_N,
    input  logic        VGA_IF_RGBEN,
    input  logic        MODE_REQ,
    input  logic [1:0]  MODE_REQ_SEL,
    input  logic        AUTO_EN,
    output logic [10:0] CURRENT_X,
    output logic [10:0] CURRENT_Y,
    output logic        PIX_VALID,
    output logic        FRAME_START,
    output logic [1:0]  MODE_SEL,
    output logic        MODE_CHANGED,
    output logic        SYNC_ERR
);

    logic [1:0]  state;
    logic [1:0]  state_nxt_c;
    logic [15:0] gap_cnt;
    logic        gap_hit_c;
    logic        frame_end_c;
    logic        in_frame_c;
    mode_t       pending;
    logic        pend_v;
    logic        req_ok_c;
    logic        auto_due_c;
    mode_t       mode_nxt_c;

    vga_xy_counter #(
        .P_DISPLAY_X (P_DISPLAY_X),
        .P_DISPLAY_Y (P_DISPLAY_Y)
    ) u_xy (
        .VGA_CLK     (VGA_CLK),
        .RST_N       (RST_N),
        .en_in       (VGA_IF_RGBEN),
        .hold        (state == ST_RESYNC),
        .clear       (gap_hit_c),
        .pix_valid   (PIX_VALID),
        .x           (CURRENT_X),
        .y           (CURRENT_Y),
        .frame_start (FRAME_START),
        .frame_end_c (frame_end_c)
    );

    // Gaps only count inside a frame; blanking at (0,0) is normal
    assign in_frame_c = (CURRENT_X != 11'd0) || (CURRENT_Y != 11'd0);
    assign gap_hit_c  = (state == ST_RUN) && !PIX_VALID && in_frame_c
                        && (gap_cnt == P_GAP_TIMEOUT - 16'd1);

    // State register
    always_ff @(posedge VGA_CLK) begin
        if (!RST_N) state <= ST_IDLE;
        else        state <= state_nxt_c;
    end

    // Next-state logic
    always_comb begin
        state_nxt_c = state;
        case (state)
            ST_IDLE:   if (PIX_VALID) state_nxt_c = ST_RUN;
            ST_RUN:    if (gap_hit_c) state_nxt_c = ST_RESYNC;
            ST_RESYNC: state_nxt_c = ST_IDLE;
            default:   state_nxt_c = ST_IDLE;
        endcase
    end

    // Consecutive enable-low cycles inside a frame
    always_ff @(posedge VGA_CLK) begin
        if (!RST_N) begin
            gap_cnt <= '0;
        end else if ((state != ST_RUN) || PIX_VALID || gap_hit_c) begin
            gap_cnt <= '0;
        end else if (in_frame_c) begin
            gap_cnt <= gap_cnt + 16'd1;
        end
    end

    // Sticky resync indication
    always_ff @(posedge VGA_CLK) begin
        if (!RST_N)                 SYNC_ERR <= 1'b0;
        else if (state == ST_RESYNC) SYNC_ERR <= 1'b1;
    end

    assign req_ok_c = MODE_REQ && (32'(MODE_REQ_SEL) < P_NUM_MODES);

`ifdef VGA_SEQ_AUTO_CYCLE_EN
    logic [7:0] frame_cnt;

    assign auto_due_c = AUTO_EN && (frame_cnt == P_AUTO_FRAMES - 8'd1);

    // Frames shown in the current mode; restarts on any mode update
    always_ff @(posedge VGA_CLK) begin
        if (!RST_N || !AUTO_EN) begin
            frame_cnt <= '0;
        end else if (frame_end_c) begin
            if (pend_v || auto_due_c)         frame_cnt <= '0;
            else if (frame_cnt != P_AUTO_FRAMES) frame_cnt <= frame_cnt + 8'd1;
        end
    end
`else
    logic auto_en_unused;

    assign auto_en_unused = AUTO_EN;
    assign auto_due_c     = 1'b0;
`endif

    // Mode to take at the end of this cycle; a pending request beats auto-cycle
    always_comb begin
        mode_nxt_c = MODE_SEL;
        if (frame_end_c) begin
            if (pend_v)          mode_nxt_c = pending;
            else if (auto_due_c) mode_nxt_c = next_mode(MODE_SEL, P_NUM_MODES);
        end
    end

    // Mode register and request capture; a request on the boundary survives the update
    always_ff @(posedge VGA_CLK) begin
        if (!RST_N) begin
            MODE_SEL     <= '0;
            MODE_CHANGED <= 1'b0;
            pending      <= '0;
            pend_v       <= 1'b0;
        end else begin
            MODE_SEL     <= mode_nxt_c;
            MODE_CHANGED <= (mode_nxt_c != MODE_SEL);
            if (frame_end_c) pend_v <= 1'b0;
            if (req_ok_c) begin
                pending <= MODE_REQ_SEL;
                pend_v  <= 1'b1;
            end
        end
    end

endmodule
